matmul_seq_ctrl: RTL

//  Sequencer for the DIM x DIM matrix-multiply datapath (register bank + MAC + result store).

---
 rtl/matmul_seq_ctrl_if.sv | 27 ++
 rtl/matmul_seq_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/matmul_seq_ctrl_if.sv
// Handshake and address bus between the matmul sequencer and its datapath/controller.
// The master modport is the sequencer side; the slave modport is the datapath/controller side.
interface matmul_seq_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              start_80;
    logic [ADDR_W-1:0] a_addr_80;
    logic [ADDR_W-1:0] b_addr_80;
    logic              mac_en_80;
    logic              acc_clr_80;
    logic              c_we_80;
    logic [ADDR_W-1:0] c_addr_80;
    logic              busy_80;
    logic              done_80;

    modport master (
        input  start_80,
        output a_addr_80, b_addr_80, mac_en_80, acc_clr_80,
        output c_we_80, c_addr_80, busy_80, done_80
    );

    modport slave (
        output start_80,
        input  a_addr_80, b_addr_80, mac_en_80, acc_clr_80,
        input  c_we_80, c_addr_80, busy_80, done_80
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Row-major sequencer for a DIM x DIM matrix multiply: issues A/B reads, steers the MAC,
// and strobes each finished C element. All outputs are registered.
module matmul_seq_ctrl #(
    parameter int DIM    = 4,
    parameter int ADDR_W = 4
) (
    input  logic               clk_80,
    input  logic               rst_80,
    matmul_seq_ctrl_if.master  bus
);
    typedef enum logic [2:0] {IDLE, MAC, DRAIN, WR, DONE} state_t;

    localparam logic [3:0] LAST = 4'(DIM - 1);

    state_t     state;
    logic [3:0] i;
    logic [3:0] j;
    logic [3:0] k;

    // Products are formed at full width, then truncated to the address width.
    function automatic logic [ADDR_W-1:0] lin(input logic [3:0] row, input logic [3:0] col);
        return ADDR_W'(32'(row) * 32'(DIM) + 32'(col));
    endfunction

    always_ff @(posedge clk_80) begin
        if (!rst_80) begin
            state          <= IDLE;
            i              <= '0;
            j              <= '0;
            k              <= '0;
            bus.a_addr_80  <= '0;
            bus.b_addr_80  <= '0;
            bus.mac_en_80  <= 1'b0;
            bus.acc_clr_80 <= 1'b0;
            bus.c_we_80    <= 1'b0;
            bus.c_addr_80  <= '0;
            bus.busy_80    <= 1'b0;
            bus.done_80    <= 1'b0;
        end else begin
            bus.mac_en_80  <= 1'b0;
            bus.acc_clr_80 <= 1'b0;
            bus.c_we_80    <= 1'b0;
            bus.done_80    <= 1'b0;
            case (state)
                IDLE: begin
                    bus.a_addr_80 <= '0;
                    bus.b_addr_80 <= '0;
                    bus.busy_80   <= 1'b0;
                    if (bus.start_80) begin
                        state       <= MAC;
                        i           <= '0;
                        j           <= '0;
                        k           <= '0;
                        bus.busy_80 <= 1'b1;
                    end
                end
                MAC: begin
                    // The read issued this cycle is consumed by the MAC next cycle.
                    bus.mac_en_80  <= 1'b1;
                    bus.acc_clr_80 <= (k == 4'd0);
                    if (k == LAST) begin
                        state <= DRAIN;
                    end else begin
                        k             <= k + 4'd1;
                        bus.a_addr_80 <= lin(i, k + 4'd1);
                        bus.b_addr_80 <= lin(k + 4'd1, j);
                    end
                end
                DRAIN: begin
                    state         <= WR;
                    bus.c_we_80   <= 1'b1;
                    bus.c_addr_80 <= lin(i, j);
                end
                WR: begin
                    if (i == LAST && j == LAST) begin
                        state       <= DONE;
                        bus.done_80 <= 1'b1;
                    end else begin
                        state <= MAC;
                        k     <= '0;
                        if (j == LAST) begin
                            j             <= '0;
                            i             <= i + 4'd1;
                            bus.a_addr_80 <= lin(i + 4'd1, 4'd0);
                            bus.b_addr_80 <= lin(4'd0, 4'd0);
                        end else begin
                            j             <= j + 4'd1;
                            bus.a_addr_80 <= lin(i, 4'd0);
                            bus.b_addr_80 <= lin(4'd0, j + 4'd1);
                        end
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.busy_80   <= 1'b0;
                    bus.a_addr_80 <= '0;
                    bus.b_addr_80 <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
